// File: rtl/ccw_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ccw_sequencer_pkg : CCW field layout, status bits, error codes and states
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ccw_sequencer_pkg;

    localparam int CCW_W       = 18;
    localparam int CCW_CC_BIT  = 17;
    localparam int CCW_SLI_BIT = 16;
    localparam int CCW_CMD_LSB = 8;
    localparam int CCW_CNT_LSB = 0;

    localparam int ST_SM   = 6;
    localparam int ST_BUSY = 4;
    localparam int ST_UC   = 1;
    localparam int ST_UE   = 0;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_NOT_OPER = 3'd1,
        ERR_BUSY     = 3'd2,
        ERR_UNIT     = 3'd3,
        ERR_LENGTH   = 3'd4,
        ERR_CHAIN    = 3'd5,
        ERR_TIMEOUT  = 3'd6,
        ERR_ABORT    = 3'd7
    } err_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ISSUE  = 3'd2,
        S_ACCEPT = 3'd3,
        S_RUN    = 3'd4,
        S_EVAL   = 3'd5,
        S_DONE   = 3'd6,
        S_WAIT   = 3'd7
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ccw_table.sv
// ---------------------------------------------------------------------------
// ccw_table : DEPTH x 18 CCW store, single write port, registered read port
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ccw_table
    import ccw_sequencer_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_index,
    input  logic [CCW_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [IW-1:0]    rd_index,
    output logic [CCW_W-1:0] rd_data
);

    logic [CCW_W-1:0] mem_q [DEPTH];
    logic [CCW_W-1:0] rd_data_q;
    logic [CCW_W-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_index] <= wr_data;
        end
    end

    // Read register only moves on rd_en so the entry stays put for re-issue.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_index];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/ccw_sequencer.sv
// ---------------------------------------------------------------------------
// ccw_sequencer : walks a CCW chain, issues each CCW to the channel, evaluates
//                 status/residual and ends with a single error code.
//                 Optional busy retry: define CCW_SEQ_RETRY_BUSY_EN.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ccw_sequencer
    import ccw_sequencer_pkg::*;
#(
    parameter int  DEPTH          = 16,
    parameter int  ACCEPT_TIMEOUT = 32,
    parameter int  MAX_RETRY      = 3,
    parameter int  RETRY_DELAY    = 16,
    localparam int IW             = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ccw_wr_en,
    input  logic [IW-1:0]    ccw_wr_index,
    input  logic [CCW_W-1:0] ccw_wr_data,
    input  logic             prog_start,
    input  logic [7:0]       prog_address,
    input  logic [IW-1:0]    prog_first_index,
    input  logic             prog_abort,
    output logic             prog_busy,
    output logic             prog_done,
    output logic [2:0]       prog_error,
    output logic [IW-1:0]    prog_index,
    output logic [7:0]       prog_status,
    output logic [7:0]       prog_res_count,
    output logic [7:0]       ch_address,
    output logic [7:0]       ch_command,
    output logic [7:0]       ch_count,
    output logic             ch_start_strobe,
    input  logic             ch_idle,
    input  logic [7:0]       ch_status,
    input  logic             ch_status_valid,
    input  logic [7:0]       ch_res_count
);

    // One width serves the accept timer, the retry delay and the retry count.
    localparam int CNT_W = $clog2(max3(ACCEPT_TIMEOUT, RETRY_DELAY, MAX_RETRY) + 1);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [7:0]       addr_q, addr_d;
    err_t             err_q, err_d;
    logic [IW-1:0]    pidx_q, pidx_d;
    logic [7:0]       pstat_q, pstat_d;
    logic [7:0]       pres_q, pres_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [7:0]       ch_address_q, ch_address_d;
    logic [7:0]       ch_command_q, ch_command_d;
    logic [7:0]       ch_count_q, ch_count_d;
`ifdef CCW_SEQ_RETRY_BUSY_EN
    logic [CNT_W-1:0] retry_q, retry_d;
`endif

    logic [CCW_W-1:0] entry;
    logic [IW:0]      next_idx;

    ccw_table #(.DEPTH(DEPTH)) u_table (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (ccw_wr_en),
        .wr_index (ccw_wr_index),
        .wr_data  (ccw_wr_data),
        .rd_en    (state_q == S_LOAD),
        .rd_index (idx_q),
        .rd_data  (entry)
    );

    // One extra bit so stepping past the last entry is detected, not wrapped.
    assign next_idx = {1'b0, idx_q} + (ch_status[ST_SM] ? (IW+1)'(2) : (IW+1)'(1));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        err_d        = err_q;
        pidx_d       = pidx_q;
        pstat_d      = pstat_q;
        pres_d       = pres_q;
        timer_d      = timer_q;
        ch_address_d = ch_address_q;
        ch_command_d = ch_command_q;
        ch_count_d   = ch_count_q;
`ifdef CCW_SEQ_RETRY_BUSY_EN
        retry_d      = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (prog_start) begin
                    state_d = S_LOAD;
                    idx_d   = prog_first_index;
                    addr_d  = prog_address;
                    err_d   = ERR_NONE;
                end
            end
            S_LOAD: begin
                state_d = S_ISSUE;
`ifdef CCW_SEQ_RETRY_BUSY_EN
                retry_d = '0;
`endif
            end
            S_ISSUE: begin
                ch_address_d = addr_q;
                ch_command_d = entry[CCW_CMD_LSB +: 8];
                ch_count_d   = entry[CCW_CNT_LSB +: 8];
                timer_d      = '0;
                state_d      = S_ACCEPT;
            end
            S_ACCEPT: begin
                if (!ch_idle) begin
                    state_d = S_RUN;
                end else if (timer_q == CNT_W'(ACCEPT_TIMEOUT - 1)) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (ch_idle) begin
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                pidx_d  = idx_q;
                pstat_d = ch_status;
                pres_d  = ch_res_count;
                state_d = S_DONE;
                if (!ch_status_valid) begin
                    err_d = ERR_NOT_OPER;
                end else if (ch_status[ST_BUSY]) begin
`ifdef CCW_SEQ_RETRY_BUSY_EN
                    if (retry_q < CNT_W'(MAX_RETRY)) begin
                        retry_d = retry_q + CNT_W'(1);
                        timer_d = '0;
                        state_d = S_WAIT;
                    end else begin
                        err_d = ERR_BUSY;
                    end
`else
                    err_d = ERR_BUSY;
`endif
                end else if (ch_status[ST_UC] | ch_status[ST_UE]) begin
                    err_d = ERR_UNIT;
                end else if ((ch_res_count != 8'd0) && !entry[CCW_SLI_BIT]) begin
                    err_d = ERR_LENGTH;
                end else if (prog_abort) begin
                    err_d = ERR_ABORT;
                end else if (!entry[CCW_CC_BIT]) begin
                    err_d = ERR_NONE;
                end else if (next_idx > (IW+1)'(DEPTH - 1)) begin
                    err_d = ERR_CHAIN;
                end else begin
                    idx_d   = next_idx[IW-1:0];
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_WAIT: begin
`ifdef CCW_SEQ_RETRY_BUSY_EN
                if (prog_abort) begin
                    err_d   = ERR_ABORT;
                    state_d = S_DONE;
                end else if (timer_q == CNT_W'(RETRY_DELAY - 1)) begin
                    state_d = S_ISSUE;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            addr_q       <= '0;
            err_q        <= ERR_NONE;
            pidx_q       <= '0;
            pstat_q      <= '0;
            pres_q       <= '0;
            timer_q      <= '0;
            ch_address_q <= '0;
            ch_command_q <= '0;
            ch_count_q   <= '0;
`ifdef CCW_SEQ_RETRY_BUSY_EN
            retry_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            err_q        <= err_d;
            pidx_q       <= pidx_d;
            pstat_q      <= pstat_d;
            pres_q       <= pres_d;
            timer_q      <= timer_d;
            ch_address_q <= ch_address_d;
            ch_command_q <= ch_command_d;
            ch_count_q   <= ch_count_d;
`ifdef CCW_SEQ_RETRY_BUSY_EN
            retry_q      <= retry_d;
`endif
        end
    end

    // Channel fields are presented combinationally during ISSUE, then held.
    assign ch_address      = ch_address_d;
    assign ch_command      = ch_command_d;
    assign ch_count        = ch_count_d;
    assign ch_start_strobe = (state_q == S_ISSUE);

    assign prog_busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign prog_done      = (state_q == S_DONE);
    assign prog_error     = err_q;
    assign prog_index     = pidx_q;
    assign prog_status    = pstat_q;
    assign prog_res_count = pres_q;

endmodule

`default_nettype wire

// File: tb/tb_ccw_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ccw_sequencer : scoreboard bench for ccw_sequencer with a mock channel/CU
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ccw_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ccw_wr_en = 1'b0;
    logic [3:0]  ccw_wr_index = '0;
    logic [17:0] ccw_wr_data = '0;
    logic        prog_start = 1'b0;
    logic [7:0]  prog_address = '0;
    logic [3:0]  prog_first_index = '0;
    logic        prog_abort = 1'b0;
    logic        prog_busy, prog_done;
    logic [2:0]  prog_error;
    logic [3:0]  prog_index;
    logic [7:0]  prog_status, prog_res_count;
    logic [7:0]  ch_address, ch_command, ch_count;
    logic        ch_start_strobe;
    logic        ch_idle = 1'b1;
    logic [7:0]  ch_status = '0;
    logic        ch_status_valid = 1'b0;
    logic [7:0]  ch_res_count = '0;

    ccw_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .ccw_wr_en(ccw_wr_en), .ccw_wr_index(ccw_wr_index), .ccw_wr_data(ccw_wr_data),
        .prog_start(prog_start), .prog_address(prog_address),
        .prog_first_index(prog_first_index), .prog_abort(prog_abort),
        .prog_busy(prog_busy), .prog_done(prog_done), .prog_error(prog_error),
        .prog_index(prog_index), .prog_status(prog_status), .prog_res_count(prog_res_count),
        .ch_address(ch_address), .ch_command(ch_command), .ch_count(ch_count),
        .ch_start_strobe(ch_start_strobe), .ch_idle(ch_idle), .ch_status(ch_status),
        .ch_status_valid(ch_status_valid), .ch_res_count(ch_res_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] err;
        logic [3:0] idx;
        logic [7:0] st;
        logic [7:0] res;
        bit         chk_last;
        int         strobes;
    } exp_t;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] cnt;
    } iss_t;

    exp_t sb[$];
    iss_t iq[$];
    logic [7:0] tbl_cmd [16];
    logic [7:0] tbl_cnt [16];

    int n_checks = 0;
    int n_pass   = 0;
    int strobe_cnt = 0;
    int done_cnt = 0;

    logic [7:0] cur_addr = '0;
    int  mock_limit = 16;
    bit  mock_busy = 0, mock_sm = 0, mock_unit = 0, mock_dead = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    always @(negedge clk) if (ch_start_strobe) strobe_cnt++;

    // Completion monitor: every prog_done must match the oldest pending expectation.
    always @(negedge clk) begin
        if (reset_n && prog_done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                check_eq("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("prog_error", 32'(prog_error), 32'(e.err));
                check_eq("strobes", 32'(strobe_cnt), 32'(e.strobes));
                if (e.chk_last) begin
                    check_eq("prog_index", 32'(prog_index), 32'(e.idx));
                    check_eq("prog_status", 32'(prog_status), 32'(e.st));
                    check_eq("prog_res_count", 32'(prog_res_count), 32'(e.res));
                end
            end
        end
    end

    // Mock channel + control unit at address 8'h1a.
    initial begin
        forever begin
            @(negedge clk);
            if (ch_start_strobe) begin
                logic [7:0] a, c;
                iss_t it;
                a = ch_address;
                c = ch_count;
                check_eq("ch_address", 32'(a), 32'(cur_addr));
                if (iq.size() == 0) begin
                    check_eq("unexpected_issue", 32'd1, 32'd0);
                end else begin
                    it = iq.pop_front();
                    check_eq("ch_command", 32'(ch_command), 32'(it.cmd));
                    check_eq("ch_count", 32'(c), 32'(it.cnt));
                end
                if (!mock_dead) begin
                    @(negedge clk);
                    ch_idle = 1'b0;
                    repeat (3) @(negedge clk);
                    if (a != 8'h1a) begin
                        ch_status_valid = 1'b0;
                        ch_status       = 8'h00;
                        ch_res_count    = c;
                    end else begin
                        ch_status_valid = 1'b1;
                        ch_status       = mock_busy ? 8'h10 : mock_unit ? 8'h0e :
                                          mock_sm ? 8'h4c : 8'h0c;
                        ch_res_count    = (int'(c) > mock_limit) ? 8'(int'(c) - mock_limit) : 8'd0;
                    end
                    ch_idle = 1'b1;
                end
            end
        end
    end

    task automatic wr(input int idx, input bit cc, input bit sli, input logic [7:0] cmd,
                      input logic [7:0] cnt);
        ccw_wr_en    = 1'b1;
        ccw_wr_index = 4'(idx);
        ccw_wr_data  = {cc, sli, cmd, cnt};
        tbl_cmd[idx] = cmd;
        tbl_cnt[idx] = cnt;
        @(negedge clk);
        ccw_wr_en = 1'b0;
    endtask

    task automatic exp_issue(input int idx);
        iss_t it;
        it.cmd = tbl_cmd[idx];
        it.cnt = tbl_cnt[idx];
        iq.push_back(it);
    endtask

    task automatic run_prog(input logic [3:0] first, input logic [7:0] addr,
                            input logic [2:0] err, input logic [3:0] idx,
                            input logic [7:0] st, input logic [7:0] res,
                            input bit chk_last, input int nstrobe,
                            input bit poke_busy, input bit poke_done);
        exp_t e;
        int   waited;
        e.err = err; e.idx = idx; e.st = st; e.res = res;
        e.chk_last = chk_last; e.strobes = strobe_cnt + nstrobe;
        sb.push_back(e);
        cur_addr         = addr;
        prog_address     = addr;
        prog_first_index = first;
        prog_start       = 1'b1;
        @(negedge clk);
        prog_start = 1'b0;
        check_eq("busy_after_start", 32'(prog_busy), 32'd1);
        check_eq("error_cleared", 32'(prog_error), 32'd0);
        if (poke_busy) begin
            repeat (3) @(negedge clk);
            prog_first_index = 4'd9;
            prog_address     = 8'h55;
            prog_start       = 1'b1;
            @(negedge clk);
            prog_start = 1'b0;
        end
        waited = 0;
        while (!prog_done && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!prog_done) check_eq("done_timeout", 32'd0, 32'd1);
        if (poke_done) begin
            prog_start = 1'b1;
            @(negedge clk);
            prog_start = 1'b0;
            check_eq("start_at_done_ignored", 32'(prog_busy), 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        int   waited;
        int   done_snap;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(prog_busy), 32'd0);
        check_eq("rst_done", 32'(prog_done), 32'd0);
        check_eq("rst_error", 32'(prog_error), 32'd0);
        check_eq("rst_strobe", 32'(ch_start_strobe), 32'd0);
        check_eq("rst_ch_fields", 32'({ch_address, ch_command, ch_count}), 32'd0);
        check_eq("rst_prog_fields", 32'({prog_index, prog_status, prog_res_count}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        wr(0, 0, 0, 8'h02, 8'd6);
        wr(2, 1, 0, 8'h01, 8'd6);
        wr(3, 0, 0, 8'h02, 8'd6);
        wr(4, 0, 0, 8'h02, 8'd16);
        wr(5, 0, 1, 8'h02, 8'd16);
        wr(6, 1, 0, 8'h02, 8'd6);
        wr(7, 0, 0, 8'h03, 8'd6);
        wr(8, 0, 0, 8'h02, 8'd6);
        wr(9, 0, 0, 8'h02, 8'd0);
        wr(14, 1, 0, 8'h02, 8'd6);
        wr(15, 1, 0, 8'h02, 8'd6);

        exp_issue(0);
        run_prog(4'd0, 8'h1a, 3'd0, 4'd0, 8'h0c, 8'd0, 1, 1, 0, 0);

        exp_issue(2); exp_issue(3);
        run_prog(4'd2, 8'h1a, 3'd0, 4'd3, 8'h0c, 8'd0, 1, 2, 1, 1);

        mock_limit = 6;
        exp_issue(4);
        run_prog(4'd4, 8'h1a, 3'd4, 4'd4, 8'h0c, 8'd10, 1, 1, 0, 0);
        exp_issue(5);
        run_prog(4'd5, 8'h1a, 3'd0, 4'd5, 8'h0c, 8'd10, 1, 1, 0, 0);
        mock_limit = 16;

        exp_issue(0);
        run_prog(4'd0, 8'h10, 3'd1, 4'd0, 8'h00, 8'd6, 1, 1, 0, 0);

        mock_busy = 1;
        exp_issue(0);
        run_prog(4'd0, 8'h1a, 3'd2, 4'd0, 8'h10, 8'd0, 1, 1, 0, 0);
        mock_busy = 0;

        exp_issue(15);
        run_prog(4'd15, 8'h1a, 3'd5, 4'd15, 8'h0c, 8'd0, 1, 1, 0, 0);

        prog_abort = 1'b1;
        exp_issue(2);
        run_prog(4'd2, 8'h1a, 3'd7, 4'd2, 8'h0c, 8'd0, 1, 1, 0, 0);
        prog_abort = 1'b0;

        mock_sm = 1;
        exp_issue(6); exp_issue(8);
        run_prog(4'd6, 8'h1a, 3'd0, 4'd8, 8'h4c, 8'd0, 1, 2, 0, 0);
        exp_issue(14);
        run_prog(4'd14, 8'h1a, 3'd5, 4'd14, 8'h4c, 8'd0, 1, 1, 0, 0);
        mock_sm = 0;

        mock_unit = 1;
        exp_issue(0);
        run_prog(4'd0, 8'h1a, 3'd3, 4'd0, 8'h0e, 8'd0, 1, 1, 0, 0);
        mock_unit = 0;

        mock_dead = 1;
        exp_issue(0);
        run_prog(4'd0, 8'h1a, 3'd6, 4'd0, 8'h00, 8'd0, 0, 1, 0, 0);
        mock_dead = 0;

        exp_issue(9);
        run_prog(4'd9, 8'h1a, 3'd0, 4'd9, 8'h0c, 8'd0, 1, 1, 0, 0);

        // Reset while the channel is running: no completion may be reported.
        exp_issue(0);
        cur_addr = 8'h1a; prog_address = 8'h1a; prog_first_index = 4'd0;
        prog_start = 1'b1;
        @(negedge clk);
        prog_start = 1'b0;
        waited = 0;
        while (ch_idle && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_eq("channel_started", 32'(ch_idle), 32'd0);
        done_snap = done_cnt;
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_busy", 32'(prog_busy), 32'd0);
        check_eq("rst_mid_strobe", 32'(ch_start_strobe), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("rst_mid_no_done", 32'(done_cnt), 32'(done_snap));
        check_eq("rst_mid_idle_after", 32'(prog_busy), 32'd0);
        waited = 0;
        while (!ch_idle && waited < 20) begin
            @(negedge clk);
            waited++;
        end

        exp_issue(0);
        run_prog(4'd0, 8'h1a, 3'd0, 4'd0, 8'h0c, 8'd0, 1, 1, 0, 0);

        repeat (5) @(negedge clk);
        check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);
        check_eq("issues_drained", 32'(iq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
